// File: rtl/craps_roll_sequencer.sv
// Craps game sequencer: turns a roll button into dice throws, feeds sums to the
// outcome FSM, reads its verdict back, and keeps the point and win/loss tallies.
module craps_roll_sequencer #(
  parameter int MIN_ROLL_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_roll,
  input  logic             i_new_game,
  input  logic [1:0]       i_state,
  output logic [3:0]       o_sum,
  output logic             o_sum_valid,
  output logic [3:0]       o_point,
  output logic             o_point_valid,
  output logic [2:0]       o_die_a,
  output logic [2:0]       o_die_b,
  output logic             o_busy,
  output logic             o_game_over,
  output logic [CNT_W-1:0] o_wins,
  output logic [CNT_W-1:0] o_losses
);

  typedef enum logic [2:0] {
    S_IDLE, S_ROLLING, S_SETTLE, S_DECIDE, S_DONE
  } state_t;

  localparam int              HOLD_W   = $clog2(MIN_ROLL_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_ROLL_CYCLES);

  state_t             r_state, w_next_state;
  logic               r_roll_prev;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [2:0]         r_die_a, r_die_b;
  logic [3:0]         r_sum, r_point;
  logic               r_sum_valid, r_point_valid;
  logic [CNT_W-1:0]   r_wins, r_losses;

  logic w_roll_edge, w_start, w_advance, w_throw, w_set_point, w_win, w_loss, w_clear;

  assign w_roll_edge = i_roll & ~r_roll_prev;

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_advance    = 1'b0;
    w_throw      = 1'b0;
    w_set_point  = 1'b0;
    w_win        = 1'b0;
    w_loss       = 1'b0;
    w_clear      = 1'b0;
    if (i_new_game) begin
      w_clear      = 1'b1;
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_roll_edge) begin
            w_start      = 1'b1;
            w_next_state = S_ROLLING;
          end
        end
        S_ROLLING: begin
          if (i_roll) begin
            w_advance = 1'b1;
          end else if (r_hold_cnt >= HOLD_MAX) begin
            w_throw      = 1'b1;
            w_next_state = S_SETTLE;
          end else begin
            w_next_state = S_IDLE;
          end
        end
        S_SETTLE: w_next_state = S_DECIDE;
        S_DECIDE: begin
          case (i_state)
            2'b01: begin
              w_set_point  = ~r_point_valid;
              w_next_state = S_IDLE;
            end
            2'b10: begin
              w_win        = 1'b1;
              w_next_state = S_DONE;
            end
            2'b11: begin
              w_loss       = 1'b1;
              w_next_state = S_DONE;
            end
            // Outcome FSM still claims come-out after a throw: drop it and wait.
            default: w_next_state = S_IDLE;
          endcase
        end
        S_DONE:  w_next_state = S_DONE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_roll_prev   <= 1'b0;
      r_hold_cnt    <= '0;
      r_die_a       <= 3'd1;
      r_die_b       <= 3'd1;
      r_sum         <= 4'd0;
      r_sum_valid   <= 1'b0;
      r_point       <= 4'd0;
      r_point_valid <= 1'b0;
      r_wins        <= '0;
      r_losses      <= '0;
    end else begin
      r_roll_prev <= i_roll;
      r_sum_valid <= w_throw;

      if (w_start)                                r_hold_cnt <= '0;
      else if (w_advance && r_hold_cnt != HOLD_MAX) r_hold_cnt <= r_hold_cnt + 1'b1;

      // Die B steps only when die A wraps, so the pair walks all 36 faces.
      if (w_advance) begin
        r_die_a <= (r_die_a == 3'd6) ? 3'd1 : r_die_a + 3'd1;
        if (r_die_a == 3'd6) r_die_b <= (r_die_b == 3'd6) ? 3'd1 : r_die_b + 3'd1;
      end

      if (w_clear) begin
        r_sum         <= 4'd0;
        r_point       <= 4'd0;
        r_point_valid <= 1'b0;
      end else begin
        if (w_throw) r_sum <= {1'b0, r_die_a} + {1'b0, r_die_b};
        if (w_set_point) begin
          r_point       <= r_sum;
          r_point_valid <= 1'b1;
        end
      end

      if (w_win  && r_wins   != '1) r_wins   <= r_wins + 1'b1;
      if (w_loss && r_losses != '1) r_losses <= r_losses + 1'b1;
    end
  end

  assign o_sum         = r_sum;
  assign o_sum_valid   = r_sum_valid;
  assign o_point       = r_point;
  assign o_point_valid = r_point_valid;
  assign o_die_a       = r_die_a;
  assign o_die_b       = r_die_b;
  assign o_busy        = (r_state == S_ROLLING) || (r_state == S_SETTLE) || (r_state == S_DECIDE);
  assign o_game_over   = (r_state == S_DONE);
  assign o_wins        = r_wins;
  assign o_losses      = r_losses;

endmodule
